// File: rtl/pipe_skid_reg.sv
// Two-entry (main + skid) valid/ready pipeline register with a fully registered in_ready.
// Optional flush input enabled by defining PIPE_SKID_REG_FLUSH_EN.
package constants;
    localparam int WORD_LENGTH = 32;
endpackage

module pipe_skid_reg #(
    parameter int n = constants::WORD_LENGTH
) (
    input  logic         clk,
    input  logic         rst,
`ifdef PIPE_SKID_REG_FLUSH_EN
    input  logic         flush,
`endif
    input  logic         in_valid,
    input  logic [n-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [n-1:0] out_data,
    input  logic         out_ready
);

    // Handshake: a beat transfers on a port in any cycle where valid and ready are both
    // high at posedge clk; a producer holds valid/data until that happens.

    // State bits are {main_v, skid_v}; skid_v without main_v is the unreachable encoding.
    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        ILLEGAL = 2'b01,
        BUSY    = 2'b10,
        FULL    = 2'b11
    } state_t;

    state_t       state_q, state_d;
    logic [n-1:0] main_q, main_d;
    logic [n-1:0] skid_q, skid_d;
    logic         in_fire;
    logic         out_fire;

    assign in_ready  = ~state_q[0];
    assign out_valid = state_q[1];
    assign out_data  = main_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                case ({in_fire, out_fire})
                    2'b11: main_d = in_data;
                    2'b10: begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end
                    2'b01: state_d = EMPTY;
                    default: ;
                endcase
            end
            FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
`ifdef PIPE_SKID_REG_FLUSH_EN
        // Flush drops occupancy and any beat arriving this cycle; data flops keep their contents.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg at n=16.
// Covers PIPE_SKID_REG_FLUSH_EN behaviour when that macro is defined.
module tb_pipe_skid_reg;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.n(W)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef PIPE_SKID_REG_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    // Advance one clock and settle just after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD; out_ready = 1'b0;
        step(); step();
        rst = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++;
        if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_nothing_captured got=%b exp=0", out_valid); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = W'(i);
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== W'(i)) begin
                n_fail++; $display("FAIL stream_beat%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, W'(i));
            end
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready%0d got=%b exp=1", i, in_ready); end
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'hAAAA;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hAAAA || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_first got v=%b d=%h r=%b exp v=1 d=aaaa r=1", out_valid, out_data, in_ready);
        end
        in_data = 16'hBBBB;
        step();
        n_checks++;
        if (in_ready !== 1'b0 || out_data !== 16'hAAAA) begin
            n_fail++; $display("FAIL bp_full got r=%b d=%h exp r=0 d=aaaa", in_ready, out_data);
        end
        in_data = 16'hCCCC;
        step();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'hAAAA) begin
            n_fail++; $display("FAIL bp_stall_stable got r=%b v=%b d=%h exp r=0 v=1 d=aaaa", in_ready, out_valid, out_data);
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hBBBB || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_second got v=%b d=%h r=%b exp v=1 d=bbbb r=1", out_valid, out_data, in_ready);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hCCCC) begin
            n_fail++; $display("FAIL bp_third got v=%b d=%h exp v=1 d=cccc", out_valid, out_data);
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h1111;
        step();
        in_data = 16'h2222; out_ready = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h2222 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL simul_busy got v=%b d=%h r=%b exp v=1 d=2222 r=1", out_valid, out_data, in_ready);
        end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL simul_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h5555;
        step();
        in_data = 16'h6666;
        step();
        n_checks++;
        if (in_ready !== 1'b0 || out_data !== 16'h5555) begin
            n_fail++; $display("FAIL midrst_full got r=%b d=%h exp r=0 d=5555", in_ready, out_data);
        end
        in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0000) begin
            n_fail++; $display("FAIL midrst_after got v=%b r=%b d=%h exp v=0 r=1 d=0000", out_valid, in_ready, out_data);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_emit%0d got=%b exp=0", i, out_valid); end
        end
    endtask

`ifdef PIPE_SKID_REG_FLUSH_EN
    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h3333;
        step();
        in_data = 16'h4444;
        step();
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full got r=%b exp=0", in_ready); end
        flush = 1'b1; in_data = 16'h7777;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_after got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_emit%0d got=%b exp=0", i, out_valid); end
        end
        in_valid = 1'b1; in_data = 16'h8888;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h8888) begin
            n_fail++; $display("FAIL flush_resume got v=%b d=%h exp v=1 d=8888", out_valid, out_data);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_mid_reset();
`ifdef PIPE_SKID_REG_FLUSH_EN
        test_flush();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
